booth_seq_divider: RTL and testbench
====================================

Name: booth_seq_divider

Overview:
- Sequential signed integer divider; the inverse of the Booth multiplier step chain in the conv layer.
- Used for average-pooling and normalisation, where an accumulated value is divided by a window size or scale.
- Restoring algorithm: one quotient bit per clock, with a start/done handshake toward the conv-layer controller.
- Quotient truncates toward zero. Remainder takes the sign of the dividend.

Parameters:
- WIDTH, 8: bit width of the dividend, divisor, quotient and remainder (two's complement).
- CNT_W, $clog2(WIDTH+1): width of the iteration counter. Derived value; never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- dividend  in  WIDTH  signed dividend; sampled with start.
- divisor  in  WIDTH  signed divisor; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results valid from this cycle.
- quotient  out  WIDTH  signed quotient; held until the next accepted start.
- remainder  out  WIDTH  signed remainder; held until the next accepted start.
- div_by_zero  out  1  status for the last operation; held with the results.
- overflow  out  1  set for MIN/-1; held with the results.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy, done, quotient, remainder, div_by_zero and overflow all go to 0.
  - Counter and internal registers are cleared.
  - A reset mid-operation aborts the operation and produces no done.
- States: IDLE, ITER, FIX, DONE.
- IDLE:
  - On start=1, register |dividend| and |divisor| (WIDTH+1 bits, so |MIN| fits), the two operand sign bits, and the zero-divisor and MIN/-1 conditions.
  - Clear counter and partial remainder, then go to ITER.
  - A divisor of 0 goes straight to FIX.
- ITER:
  - Each cycle performs one restoring step: shift {partial remainder, quotient} left by 1, shifting in the next dividend MSB; trial-subtract |divisor|.
  - If the trial result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
  - The counter increments each cycle. After WIDTH steps, go to FIX.
- FIX:
  - Quotient is negated if the operand signs differ.
  - Remainder is negated if the dividend was negative.
  - Load the quotient, remainder and flags into the output registers, then go to DONE.
- DONE: done=1 for exactly one cycle and busy drops to 0 in the same cycle; return to IDLE.
- Latency: start is sampled at edge E0 and done is high in the cycle after edge E(WIDTH+2). That is WIDTH+3 cycles start-to-done, or 3 cycles for divide-by-zero.
- Handshake:
  - start while busy or during DONE is ignored. No queueing.
  - start in the cycle immediately after done is accepted (back-to-back).
- Divide by zero: div_by_zero=1, quotient = all ones (-1), remainder = dividend, overflow=0.
- MIN / -1 (for example -128/-1): overflow=1, remainder=0, quotient as set by the optional feature below.
- Outputs are registered; none depend combinationally on the inputs.

Optional Feature:
- Macro: BOOTH_DIV_SAT_EN.
- Defined: on MIN/-1, quotient saturates to MAX (127 for WIDTH=8).
- Undefined: quotient wraps to MIN (-128), the natural two's-complement result.
- overflow is set in both builds.

Decomposition:
- Package booth_div_pkg holds:
  - the state enum (IDLE, ITER, FIX, DONE);
  - default WIDTH;
  - the helper function for the CNT_W derivation;
  - the constants DIV_MAX and DIV_MIN for sign fixup and saturation.
- Sub-module booth_div_substep is the combinational single restoring step: partial remainder, incoming bit and |divisor| in; next partial remainder and quotient bit out. It mirrors the multiplier sub-step and is instantiated once, inside the ITER datapath.

Test Plan:
- 100/7: quotient=14, remainder=2, done at cycle 11 after start, flags 0.
- -100/7 then 100/-7 back-to-back, with the second start in the cycle after done: (-14, -2), then (-14, 2); both dones observed with no lost request.
- 5/0: done 3 cycles after start, div_by_zero=1, quotient=-1, remainder=5.
- -128/-1:
  - BOOTH_DIV_SAT_EN defined: quotient=127, overflow=1.
  - Undefined: quotient=-128, overflow=1.
- start pulsed at cycles 3 and 6 of a busy operation: ignored; results match the first operands; exactly one done.
- rst_n pulled low at ITER cycle 4: all outputs 0 immediately; no done; a new operation after release completes correctly, for example 127/1 gives (127, 0).

Source files
------------

// File: rtl/booth_seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Build option: define BOOTH_DIV_SAT_EN to saturate the MIN/-1 quotient instead of wrapping.
package booth_div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } div_state_e;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam logic [DIV_WIDTH-1:0] DIV_MAX = {1'b0, {(DIV_WIDTH-1){1'b1}}};
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage

// File: rtl/booth_seq_divider_if.sv
// Start/done handshake and operand/result bus between the conv-layer controller and the divider.
interface booth_seq_divider_if
  import booth_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/booth_seq_divider_substep.sv
// One combinational restoring-division step on magnitudes: shift in a dividend bit, trial-subtract.
module booth_div_substep #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH:0]   divisor_mag,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             unused_top_bits;

  assign shifted = {rem_in, bit_in};
  assign trial   = {1'b0, shifted} - {1'b0, divisor_mag};
  assign q_bit   = ~trial[WIDTH+1];

  // The kept remainder is always below |divisor| <= 2^(WIDTH-1), so the top bit is never needed.
  assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

  assign unused_top_bits = trial[WIDTH] ^ shifted[WIDTH];

endmodule

// File: rtl/booth_seq_divider.sv
// Sequential signed restoring divider, one quotient bit per clock, start/done handshake.
// Build option: BOOTH_DIV_SAT_EN saturates the MIN/-1 quotient to MAX (otherwise wraps to MIN).
module booth_seq_divider
  import booth_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  booth_seq_divider_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef BOOTH_DIV_SAT_EN
  localparam logic [WIDTH-1:0] OVF_QUOT = Q_MAX;
`else
  localparam logic [WIDTH-1:0] OVF_QUOT = Q_MIN;
`endif

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]   dvs_mag;
  logic             dvd_neg;
  logic             dvs_neg;
  logic             dz_pend;
  logic             ov_pend;
  logic [WIDTH-1:0] rem_part;
  logic [WIDTH-1:0] quo;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dz_q;
  logic             ov_q;

  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] in_dvd_mag;
  logic [WIDTH-1:0] in_dvs_mag;

  // |MIN| is 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
  assign in_dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign in_dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

  booth_div_substep #(.WIDTH(WIDTH)) u_substep (
    .rem_in      (rem_part),
    .bit_in      (dvd_mag[WIDTH-1]),
    .divisor_mag (dvs_mag),
    .rem_out     (rem_next),
    .q_bit       (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dvd_mag  <= '0;
      dvs_mag  <= '0;
      dvd_neg  <= 1'b0;
      dvs_neg  <= 1'b0;
      dz_pend  <= 1'b0;
      ov_pend  <= 1'b0;
      rem_part <= '0;
      quo      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      dz_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd_mag  <= in_dvd_mag;
            dvs_mag  <= {1'b0, in_dvs_mag};
            dvd_neg  <= bus.dividend[WIDTH-1];
            dvs_neg  <= bus.divisor[WIDTH-1];
            dz_pend  <= (bus.divisor == '0);
            ov_pend  <= (bus.dividend == Q_MIN) && (bus.divisor == '1);
            cnt      <= '0;
            rem_part <= '0;
            quo      <= '0;
            busy_q   <= 1'b1;
            state    <= (bus.divisor == '0) ? FIX : ITER;
          end
        end
        ITER: begin
          rem_part <= rem_next;
          quo      <= {quo[WIDTH-2:0], q_bit};
          dvd_mag  <= {dvd_mag[WIDTH-2:0], 1'b0};
          cnt      <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          // Divide-by-zero never ran ITER, so dvd_mag still holds the untouched magnitude.
          if (dz_pend) begin
            quot_q <= '1;
            rem_q  <= dvd_neg ? -dvd_mag : dvd_mag;
            dz_q   <= 1'b1;
            ov_q   <= 1'b0;
          end else if (ov_pend) begin
            quot_q <= OVF_QUOT;
            rem_q  <= '0;
            dz_q   <= 1'b0;
            ov_q   <= 1'b1;
          end else begin
            quot_q <= (dvd_neg ^ dvs_neg) ? -quo : quo;
            rem_q  <= dvd_neg ? -rem_part : rem_part;
            dz_q   <= 1'b0;
            ov_q   <= 1'b0;
          end
          state <= DONE;
        end
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ov_q;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Self-checking bench for booth_seq_divider: integer-arithmetic reference model plus directed cases.
// Honours BOOTH_DIV_SAT_EN for the MIN/-1 expectation.
module tb_booth_seq_divider;
  import booth_div_pkg::*;

  localparam int WIDTH = DIV_WIDTH;
  localparam int MINV  = -(1 << (WIDTH - 1));
  localparam int LAT   = WIDTH + 3;
  localparam int LAT_Z = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   edge_cnt = 0;

  booth_seq_divider_if #(.WIDTH(WIDTH)) bus ();

  booth_seq_divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Reference arithmetic: SV signed / and % truncate toward zero, remainder follows the dividend.
  function automatic void refDiv(input int a, input int b,
                                 output int q, output int r, output int dz, output int ov);
    dz = 0;
    ov = 0;
    if (b == 0) begin
      q  = -1;
      r  = a;
      dz = 1;
    end else if (a == MINV && b == -1) begin
`ifdef BOOTH_DIV_SAT_EN
      q = int'($signed(DIV_MAX));
`else
      q = int'($signed(DIV_MIN));
`endif
      r  = 0;
      ov = 1;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  bit have_op;
  int acc_edge, op_lat;
  int exp_q, exp_r, exp_dz, exp_ov;
  int held_q, held_r, held_dz, held_ov;

  // Transaction-level model: one accepted request at a time, results appear after a fixed latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_op = 1'b0;
      held_q  = 0;
      held_r  = 0;
      held_dz = 0;
      held_ov = 0;
    end else begin
      edge_cnt++;
      if (have_op && edge_cnt == acc_edge + op_lat - 1) begin
        held_q  = exp_q;
        held_r  = exp_r;
        held_dz = exp_dz;
        held_ov = exp_ov;
      end
      if (bus.start && (!have_op || edge_cnt >= acc_edge + op_lat)) begin
        have_op  = 1'b1;
        acc_edge = edge_cnt;
        refDiv(int'($signed(bus.dividend)), int'($signed(bus.divisor)),
               exp_q, exp_r, exp_dz, exp_ov);
        op_lat = (exp_dz != 0) ? LAT_Z : LAT;
      end
    end
  end

  // Every cycle: handshake timing always, results whenever the divider is not busy.
  always @(negedge clk) begin
    int eb, ed;
    if (!rst_n) begin
      checkOutput("rst_busy", int'(bus.busy), 0);
      checkOutput("rst_done", int'(bus.done), 0);
      checkOutput("rst_quot", int'($signed(bus.quotient)), 0);
      checkOutput("rst_rem", int'($signed(bus.remainder)), 0);
      checkOutput("rst_dz", int'(bus.div_by_zero), 0);
      checkOutput("rst_ov", int'(bus.overflow), 0);
    end else begin
      eb = (have_op && edge_cnt >= acc_edge && edge_cnt <= acc_edge + op_lat - 2) ? 1 : 0;
      ed = (have_op && edge_cnt == acc_edge + op_lat - 1) ? 1 : 0;
      checkOutput("busy", int'(bus.busy), eb);
      checkOutput("done", int'(bus.done), ed);
      if (eb == 0) begin
        checkOutput("quot", int'($signed(bus.quotient)), held_q);
        checkOutput("rem", int'($signed(bus.remainder)), held_r);
        checkOutput("dz", int'(bus.div_by_zero), held_dz);
        checkOutput("ov", int'(bus.overflow), held_ov);
      end
    end
  end

  task automatic applyStimulus(input int a, input int b, output int t0);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = WIDTH'(a);
    bus.divisor  = WIDTH'(b);
    t0 = edge_cnt;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        lat = edge_cnt - t0;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=no_done expected=done within 40 cycles", name);
    end
  endtask

  task automatic checkResult(input string name, input int lat, input int lat_e,
                             input int q_e, input int r_e, input int dz_e, input int ov_e);
    checkOutput({name, "_lat"}, lat, lat_e);
    checkOutput({name, "_q"}, int'($signed(bus.quotient)), q_e);
    checkOutput({name, "_r"}, int'($signed(bus.remainder)), r_e);
    checkOutput({name, "_dz"}, int'(bus.div_by_zero), dz_e);
    checkOutput({name, "_ov"}, int'(bus.overflow), ov_e);
  endtask

  task automatic countDones(input string name, input int cycles);
    int n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    checkOutput(name, n, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=still_running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, lat, q, r, dz, ov, a, b;
    rst_n        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    refDiv(100, 7, q, r, dz, ov);
    checkOutput("model_100_7_q", q, 14);
    checkOutput("model_100_7_r", r, 2);
    refDiv(-100, 7, q, r, dz, ov);
    checkOutput("model_m100_7_r", r, -2);
    refDiv(100, -7, q, r, dz, ov);
    checkOutput("model_100_m7_r", r, 2);

    $display("[TB] 100/7");
    applyStimulus(100, 7, t0);
    waitDone("d100_7", t0, lat);
    checkResult("d100_7", lat, 11, 14, 2, 0, 0);

    $display("[TB] back-to-back -100/7 then 100/-7");
    applyStimulus(-100, 7, t0);
    waitDone("dm100_7", t0, lat);
    checkResult("dm100_7", lat, 11, -14, -2, 0, 0);
    applyStimulus(100, -7, t0);
    waitDone("d100_m7", t0, lat);
    checkResult("d100_m7", lat, 11, -14, 2, 0, 0);

    $display("[TB] 5/0");
    applyStimulus(5, 0, t0);
    waitDone("d5_0", t0, lat);
    checkResult("d5_0", lat, 3, -1, 5, 1, 0);

    $display("[TB] -128/-1");
    applyStimulus(-128, -1, t0);
    waitDone("dmin_m1", t0, lat);
`ifdef BOOTH_DIV_SAT_EN
    checkResult("dmin_m1", lat, 11, 127, 0, 0, 1);
`else
    checkResult("dmin_m1", lat, 11, -128, 0, 0, 1);
`endif

    $display("[TB] start pulses while busy");
    applyStimulus(100, 7, t0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.dividend = WIDTH'(50); bus.divisor = WIDTH'(3);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone("ignore", t0, lat);
    checkResult("ignore", lat, 11, 14, 2, 0, 0);
    countDones("ignore_extra_done", 15);

    $display("[TB] reset mid-operation");
    applyStimulus(-100, 7, t0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(bus.busy), 0);
    checkOutput("abort_quot", int'($signed(bus.quotient)), 0);
    checkOutput("abort_rem", int'($signed(bus.remainder)), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    countDones("abort_no_done", 15);
    applyStimulus(127, 1, t0);
    waitDone("d127_1", t0, lat);
    checkResult("d127_1", lat, 11, 127, 0, 0, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      a = ($urandom_range(0, 7) == 0) ? MINV : int'($urandom_range(0, 255)) - 128;
      case ($urandom_range(0, 7))
        0:       b = 0;
        1:       b = -1;
        default: b = int'($urandom_range(0, 255)) - 128;
      endcase
      bus.start    = ($urandom_range(0, 2) == 0);
      bus.dividend = WIDTH'(a);
      bus.divisor  = WIDTH'(b);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
